left_shift_sequencer: RTL



---
 rtl/left_shift_sequencer_pkg.sv | 19 +
 rtl/left_shift_sequencer_step.sv | 21 ++
 rtl/left_shift_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/left_shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle left-shift sequencer: state encoding,
// default widths and the sign-change helper used by the single-step stage.
package left_shift_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A one-position left shift changes the sign exactly when the two top bits differ.
  function automatic logic sign_change(input logic msb, input logic next_msb);
    return msb ^ next_msb;
  endfunction

endpackage

// File: rtl/left_shift_sequencer_step.sv
// Single-position logical left-shift stage: next work value, bit shifted out of
// the MSB, and whether this step flips the sign bit.
import left_shift_sequencer_pkg::*;

module left_shift_step #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             sgn_chg
);

  // Purely combinational shift by one with zero fill.
  always_comb begin
    y       = {x[WIDTH-2:0], 1'b0};
    cout    = x[WIDTH-1];
    sgn_chg = sign_change(x[WIDTH-1], x[WIDTH-2]);
  end

endmodule

// File: rtl/left_shift_sequencer.sv
// Multi-cycle logical left shifter: accepts an operand and count, shifts one
// position per clock through left_shift_step, then holds the result until consumed.
import left_shift_sequencer_pkg::*;

module left_shift_sequencer #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [CNT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_cout,
  output logic             out_ovf
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_f_q, out_f_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;

  logic [CNT_W-1:0] amt_sat_s;
  logic [WIDTH-1:0] step_y_s;
  logic             step_cout_s;
  logic             step_chg_s;

  left_shift_step #(.WIDTH(WIDTH)) u_step (
    .x       (work_q),
    .y       (step_y_s),
    .cout    (step_cout_s),
    .sgn_chg (step_chg_s)
  );

  // Saturate the requested count at WIDTH; anything larger shifts everything out.
  always_comb begin
    if (in_amt > CNT_W'(WIDTH)) begin
      amt_sat_s = CNT_W'(WIDTH);
    end else begin
      amt_sat_s = in_amt;
    end
  end

  // Next-state logic for the FSM, working register, counter and flags.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d = in_x;
          cnt_d  = amt_sat_s;
          cout_d = 1'b0;
          ovf_d  = 1'b0;
          if (amt_sat_s == {CNT_W{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = step_y_s;
        cout_d = step_cout_s;
        ovf_d  = ovf_q | step_chg_s;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        work_d  = {WIDTH{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // Output registers track the next state so the ports come straight from flops
  // and read zero whenever the result is not being presented.
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    if (out_valid_d) begin
      out_f_d    = work_d;
      out_cout_d = cout_d;
      out_ovf_d  = ovf_d;
    end else begin
      out_f_d    = {WIDTH{1'b0}};
      out_cout_d = 1'b0;
      out_ovf_d  = 1'b0;
    end
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_f_q     <= {WIDTH{1'b0}};
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_f_q     <= out_f_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_f     = out_f_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule
